uart_count_reporter: RTL

Transmit sequencer for the binary counter's UART link. On each report request it snapshots the counter value and drives the UART byte transmitter, one byte at a time, with a frame of uppercase ASCII hex digits followed by CR LF. It sits between the counter and the UART transmitter, which is paced by the baud-rate generator's `tick` at 115200 baud from the 50 MHz `clk`. It owns the transmitter's start/done handshake, so the transmitter never receives a start while it is busy.

---
 rtl/uart_count_reporter_if.sv | 10 +
 rtl/uart_count_reporter.sv | 118 +++++++++++
 2 files changed

// File: rtl/uart_count_reporter_if.sv
// Byte handshake between the count reporter and the UART byte transmitter.
// The reporter is the master: it issues start/data and receives done.
interface uart_count_reporter_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;

   modport master (output tx_start, output tx_data, input tx_done);
   modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_count_reporter.sv
// Transmit sequencer: on report, snapshots count and sends it as uppercase
// ASCII hex (MSB nibble first) followed by CR LF, one byte per tx_done.
module uart_count_reporter #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [COUNT_WIDTH-1:0] count,
   input  logic                   report,
   uart_count_reporter_if.master  tx,
   output logic                   busy,
   output logic                   overrun,
   output logic [7:0]             frame_count
);
   localparam int NIBBLES = COUNT_WIDTH / 4;
   localparam int NBYTES  = NIBBLES + 2;
   localparam int IDX_W   = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                 state_reg, state_next;
   logic [COUNT_WIDTH-1:0] snap_reg, snap_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [IDX_W-1:0]       idx_inc;
   logic                   tx_start_reg, tx_start_next;
   logic [7:0]             tx_data_reg, tx_data_next;
   logic                   busy_reg, busy_next;
   logic                   overrun_reg, overrun_next;
   logic [7:0]             frame_count_reg, frame_count_next;
   logic [7:0]             frame_byte [NBYTES];

   function automatic logic [7:0] hex_ascii(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
   endfunction

   // Whole frame laid out from the frozen snapshot, indexed by byte position.
   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_digit
         assign frame_byte[gi] = hex_ascii(snap_reg[COUNT_WIDTH-1-4*gi -: 4]);
      end
   endgenerate
   assign frame_byte[NIBBLES]   = 8'h0D;
   assign frame_byte[NIBBLES+1] = 8'h0A;

   assign idx_inc = idx_reg + 1'b1;

   always_comb begin
      state_next       = state_reg;
      snap_next        = snap_reg;
      idx_next         = idx_reg;
      tx_start_next    = 1'b0;
      tx_data_next     = tx_data_reg;
      busy_next        = busy_reg;
      overrun_next     = overrun_reg;
      frame_count_next = frame_count_reg;
      case (state_reg)
         IDLE: begin
            if (report) begin
               // Digit 0 comes straight from count; the snapshot isn't loaded yet.
               snap_next     = count;
               idx_next      = '0;
               tx_data_next  = hex_ascii(count[COUNT_WIDTH-1 -: 4]);
               tx_start_next = 1'b1;
               busy_next     = 1'b1;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            if (report) begin
               overrun_next = 1'b1;
            end
            // A done coincident with our own start pulse cannot belong to this byte.
            if (tx.tx_done && !tx_start_reg) begin
               if (idx_reg == LAST_IDX) begin
                  state_next       = IDLE;
                  busy_next        = 1'b0;
                  frame_count_next = frame_count_reg + 8'd1;
               end else begin
                  idx_next      = idx_inc;
                  tx_data_next  = frame_byte[idx_inc];
                  tx_start_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         snap_reg        <= '0;
         idx_reg         <= '0;
         tx_start_reg    <= 1'b0;
         tx_data_reg     <= 8'h00;
         busy_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
         frame_count_reg <= 8'h00;
      end else begin
         state_reg       <= state_next;
         snap_reg        <= snap_next;
         idx_reg         <= idx_next;
         tx_start_reg    <= tx_start_next;
         tx_data_reg     <= tx_data_next;
         busy_reg        <= busy_next;
         overrun_reg     <= overrun_next;
         frame_count_reg <= frame_count_next;
      end
   end

   assign tx.tx_start  = tx_start_reg;
   assign tx.tx_data   = tx_data_reg;
   assign busy         = busy_reg;
   assign overrun      = overrun_reg;
   assign frame_count  = frame_count_reg;
endmodule
